// File: rtl/shift_pkg.sv
// Shared definitions for the shift decode stage.
// Holds the datapath width, the shift op encodings, the decoded-request
// payload carried through the skid buffer, and the pure decode function.
package shift_pkg;

  localparam int W = 16;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic [W-1:0] data;    // operand, bit-reversed for SLL
    logic [W-1:0] shift;   // one-hot shift select
    logic [W-2:0] shiftl;  // sign-fill mask for SRA
    logic         left;    // SLL: downstream un-reverses the result
  } dec_t;

  // SLL is executed by the downstream right-shifter on a reversed operand.
  // A reserved op behaves as SRL by zero so it passes data through untouched.
  function automatic dec_t decode(input logic [1:0]   op,
                                  input logic [W-1:0] data,
                                  input logic [3:0]   shamt);
    dec_t d;
    d.data   = data;
    d.shift  = W'(1) << shamt;
    d.shiftl = '0;
    d.left   = 1'b0;
    case (op)
      OP_SLL: begin
        for (int i = 0; i < W; i++) d.data[i] = data[W-1-i];
        d.left = 1'b1;
      end
      OP_SRA: begin
        // top 'shamt' bits of the 15-bit fill mask are set
        if (data[W-1]) d.shiftl = ~({(W-1){1'b1}} >> shamt);
      end
      OP_RSV: d.shift = W'(1);
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// Two-entry skid buffer (main + skid register) with registered ready.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             drop all held entries, return to EMPTY
//   i_in_valid/o_in_ready/i_in_data     upstream handshake + payload
//   o_out_valid/i_out_ready/o_out_data  downstream handshake + payload
//
// state   | meaning
// S_EMPTY | nothing held; ready, not valid
// S_ONE   | main register holds the head entry; ready and valid
// S_FULL  | main holds head, skid holds the next entry; not ready
module shift_skid_buf #(
  parameter int PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [PW-1:0] i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [PW-1:0] o_out_data
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_acc;
  logic          w_drain;

  assign w_acc   = i_in_valid & r_in_ready;
  assign w_drain = r_out_valid & i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_acc && !w_drain)      w_state_nxt = S_FULL;
        else if (!w_acc && w_drain) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_drain) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
    if (i_flush) w_state_nxt = S_EMPTY;
  end

  // Handshake flags are registered from the next state so ready never
  // depends combinationally on i_out_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (!i_flush) begin
        case (r_state)
          S_EMPTY: if (w_acc) r_main <= i_in_data;
          S_ONE: begin
            if (w_acc && w_drain) r_main <= i_in_data;
            else if (w_acc)       r_skid <= i_in_data;
          end
          S_FULL:  if (w_drain) r_main <= r_skid;
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_main;

endmodule

// File: rtl/shift_decode_stage.sv
// Shift decode stage: decodes an accepted shift request into operand,
// one-hot shift select and SRA fill mask, buffered through a 2-entry skid
// buffer (1-cycle latency), and counts accepted reserved-op requests.
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_in_valid/o_in_ready               upstream handshake
//   i_in_op, i_in_data, i_in_shamt      request fields
//   i_flush                             discard all held requests
//   o_out_valid/i_out_ready             downstream handshake
//   o_out_data, o_out_shift, o_out_shiftl, o_out_left   decoded request
//   o_err_cnt                           saturating reserved-op count
module shift_decode_stage
  import shift_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [1:0]   i_in_op,
  input  logic [W-1:0] i_in_data,
  input  logic [3:0]   i_in_shamt,
  input  logic         i_flush,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic [W-1:0] o_out_shift,
  output logic [W-2:0] o_out_shiftl,
  output logic         o_out_left,
  output logic [7:0]   o_err_cnt
);

  dec_t       w_dec;
  dec_t       w_out;
  logic       w_acc;
  logic [7:0] r_err_cnt;

  assign w_dec = decode(i_in_op, i_in_data, i_in_shamt);

  shift_skid_buf #(
    .PW($bits(dec_t))
  ) u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (w_dec),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (w_out)
  );

  // A request presented during flush is dropped and must not be counted.
  assign w_acc = i_in_valid & o_in_ready & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (w_acc && (i_in_op == OP_RSV) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_out_data   = w_out.data;
  assign o_out_shift  = w_out.shift;
  assign o_out_shiftl = w_out.shiftl;
  assign o_out_left   = w_out.left;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_shift_decode_stage.sv
module tb_shift_decode_stage;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [1:0]  i_in_op = 2'b00;
  logic [15:0] i_in_data = 16'h0;
  logic [3:0]  i_in_shamt = 4'h0;
  logic        i_flush = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_out_data;
  logic [15:0] o_out_shift;
  logic [14:0] o_out_shiftl;
  logic        o_out_left;
  logic [7:0]  o_err_cnt;

  always #5 clk = ~clk;

  shift_decode_stage #(.W(16)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_op      (i_in_op),
    .i_in_data    (i_in_data),
    .i_in_shamt   (i_in_shamt),
    .i_flush      (i_flush),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_out_shift  (o_out_shift),
    .o_out_shiftl (o_out_shiftl),
    .o_out_left   (o_out_left),
    .o_err_cnt    (o_err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q[$];
  int err_model = 0;
  bit mon_en = 1'b0;
  bit m_in_ready = 1'b1;
  bit accepted = 1'b0;
  int sz;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: {data, shift, shiftl, left} from the op/shamt rules.
  function automatic logic [47:0] model(input logic [1:0] op, input logic [15:0] d,
                                        input logic [3:0] sh);
    int eff;
    logic [15:0] od;
    logic [15:0] osh;
    logic [14:0] ofl;
    logic ol;
    eff = (op == 2'b11) ? 0 : int'(sh);
    od  = d;
    ol  = (op == 2'b00);
    if (op == 2'b00) for (int i = 0; i < 16; i++) od[i] = d[15-i];
    osh = 16'(1 << eff);
    ofl = '0;
    for (int j = 0; j < 15; j++)
      if (op == 2'b10 && d[15] && j >= 15 - eff) ofl[j] = 1'b1;
    return {od, osh, ofl, ol};
  endfunction

  // Monitor: compares DUT handshake and payload against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      sz = exp_q.size();
      check("out_valid", 48'(o_out_valid), 48'(sz > 0));
      check("in_ready", 48'(o_in_ready), 48'(sz < 2));
      check("err_cnt", 48'(o_err_cnt), 48'((err_model > 255) ? 255 : err_model));
      m_in_ready = (sz < 2);
      if (o_out_valid && sz > 0) begin
        check("out_payload", {o_out_data, o_out_shift, o_out_shiftl, o_out_left}, exp_q[0]);
        if (i_out_ready && !i_rst) void'(exp_q.pop_front());
      end
    end
  end

  // One clock: model bookkeeping for the current inputs, then advance.
  task automatic step();
    @(negedge clk);
    #1;
    accepted = 1'b0;
    if (i_rst) begin
      exp_q.delete();
      err_model = 0;
    end else if (i_flush) begin
      exp_q.delete();
    end else if (i_in_valid && m_in_ready) begin
      exp_q.push_back(model(i_in_op, i_in_data, i_in_shamt));
      accepted = 1'b1;
      if (i_in_op == 2'b11 && err_model < 255) err_model++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name);
    for (int k = 0; k < 50; k++) begin
      step();
      if (accepted) break;
    end
    check(name, 48'(accepted), 48'(1));
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] sh);
    i_in_valid = 1'b1;
    i_in_op    = op;
    i_in_data  = d;
    i_in_shamt = sh;
    wait_accept("send_accept");
    i_in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 48'(o_out_valid), 48'(0));
    check({tag, "_in_ready"}, 48'(o_in_ready), 48'(1));
    check({tag, "_out_data"}, 48'(o_out_data), 48'(0));
    check({tag, "_out_shift"}, 48'(o_out_shift), 48'(0));
    check({tag, "_out_shiftl"}, 48'(o_out_shiftl), 48'(0));
    check({tag, "_out_left"}, 48'(o_out_left), 48'(0));
    check({tag, "_err_cnt"}, 48'(o_err_cnt), 48'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    mon_en = 1'b1;
    i_rst = 1'b0;

    // SLL / SRA / SRL decode with a free-flowing downstream
    i_out_ready = 1'b1;
    send(2'b00, 16'h0001, 4'd3);
    check("sll_data", 48'(o_out_data), 48'h8000);
    check("sll_shift", 48'(o_out_shift), 48'h0008);
    check("sll_shiftl", 48'(o_out_shiftl), 48'h0000);
    check("sll_left", 48'(o_out_left), 48'(1));
    send(2'b10, 16'h8000, 4'd4);
    check("sra_shift", 48'(o_out_shift), 48'h0010);
    check("sra_shiftl", 48'(o_out_shiftl), 48'h7800);
    check("sra_left", 48'(o_out_left), 48'(0));
    send(2'b01, 16'h8000, 4'd4);
    check("srl_shiftl", 48'(o_out_shiftl), 48'h0000);
    send(2'b10, 16'hFFFF, 4'd0);
    check("sra0_shift", 48'(o_out_shift), 48'h0001);
    check("sra0_shiftl", 48'(o_out_shiftl), 48'h0000);
    step();

    // Back-to-back A, B, C into a stalled downstream
    i_out_ready = 1'b0;
    send(2'b01, 16'h1234, 4'd1);
    send(2'b00, 16'h00F0, 4'd2);
    check("full_in_ready", 48'(o_in_ready), 48'(0));
    check("full_head", 48'(o_out_data), 48'h1234);
    i_in_valid = 1'b1;
    i_in_op    = 2'b10;
    i_in_data  = 16'hA5A5;
    i_in_shamt = 4'd7;
    step();
    check("c_not_accepted", 48'(accepted), 48'(0));
    step();
    check("stall_head", 48'(o_out_data), 48'h1234);
    i_out_ready = 1'b1;
    wait_accept("c_accept");
    i_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Flush while FULL with a request presented
    i_out_ready = 1'b0;
    send(2'b11, 16'h5555, 4'd9);
    send(2'b01, 16'h0F0F, 4'd3);
    i_in_valid = 1'b1;
    i_in_op    = 2'b11;
    i_in_data  = 16'hDEAD;
    i_flush    = 1'b1;
    step();
    i_flush    = 1'b0;
    i_in_valid = 1'b0;
    check("flush_out_valid", 48'(o_out_valid), 48'(0));
    check("flush_in_ready", 48'(o_in_ready), 48'(1));
    check("flush_err_cnt", 48'(o_err_cnt), 48'(1));
    i_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Reset while FULL
    i_out_ready = 1'b0;
    send(2'b11, 16'h1111, 4'd2);
    send(2'b11, 16'h2222, 4'd5);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_reset_outputs("rst_full");

    // Reserved op 300 times: counter saturates
    i_out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(2'b11, 16'($urandom), 4'($urandom));
      check("rsv_shift", 48'(o_out_shift), 48'h0001);
    end
    step();
    check("err_saturated", 48'(o_err_cnt), 48'd255);

    // Random traffic with random back-pressure and occasional flush
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      i_in_valid  = ($urandom_range(0, 3) != 0);
      i_in_op     = 2'($urandom);
      i_in_data   = 16'($urandom);
      i_in_shamt  = 4'($urandom);
      i_out_ready = ($urandom_range(0, 3) != 0);
      i_flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    i_in_valid  = 1'b0;
    i_flush     = 1'b0;
    i_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("final_drain", 48'(o_out_valid), 48'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
